// File: rtl/pop_sequence_monitor.sv
// -----------------------------------------------------------------------------
// pop_sequence_monitor
//
// Watches the timing signals of a pulsed optically-pumped (POP) sequence and
// measures each phase of one complete cycle:
//
//    pump high -> dark (pump low, MW low) -> MW pulse 1 -> free precession
//    (MW low) -> MW pulse 2 -> gap -> probe high (sample must be seen)
//
// All six durations are counted in clk_2M5 cycles. They are published
// together, with a one-cycle result_valid strobe, only when a cycle completes
// cleanly. Any ordering violation or over-long phase aborts the cycle with a
// one-cycle seq_error strobe and a sticky error_code.
//
// Ports
//    clk_2M5       in   2.5 MHz clock, all logic on its rising edge
//    rst_n         in   synchronous, active-low reset
//    pump          in   pump pulse
//    probe         in   probe pulse
//    MW            in   microwave pulse (two per cycle)
//    sample        in   acquisition window, must be high at some point in probe
//    pump_width    out  cycles pump was high
//    dark_width    out  cycles between pump fall and first MW rise
//    mw1_width     out  cycles first MW pulse was high
//    fp_width      out  cycles between the two MW pulses
//    mw2_width     out  cycles second MW pulse was high
//    probe_width   out  cycles probe was high
//    result_valid  out  one-cycle strobe, all six widths just updated
//    seq_error     out  one-cycle strobe, sequence violation detected
//    error_code    out  code of the latest violation (held):
//                       1 pump rise outside IDLE, 2 early probe rise,
//                       3 misplaced MW rise, 4 timeout, 5 no sample in probe
//    cycle_count   out  number of completed valid cycles (wraps)
// -----------------------------------------------------------------------------
module pop_sequence_monitor #(
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic        clk_2M5,
   input  logic        rst_n,
   input  logic        pump,
   input  logic        probe,
   input  logic        MW,
   input  logic        sample,
   output logic [15:0] pump_width,
   output logic [15:0] dark_width,
   output logic [15:0] mw1_width,
   output logic [15:0] fp_width,
   output logic [15:0] mw2_width,
   output logic [15:0] probe_width,
   output logic        result_valid,
   output logic        seq_error,
   output logic [2:0]  error_code,
   output logic [15:0] cycle_count
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PUMP,
      ST_DARK,
      ST_MW1,
      ST_FP,
      ST_MW2,
      ST_WAIT_PROBE,
      ST_PROBE
   } state_t;

   // What the next-state logic decided to do this cycle. Every value other
   // than EV_NONE is a state entry (possibly re-entry of PUMP), so the
   // duration counter restarts on any of them.
   typedef enum logic [2:0] {
      EV_NONE,
      EV_ADVANCE,
      EV_TIMEOUT,
      EV_PUMP_ERR,
      EV_PROBE_ERR,
      EV_MW_ERR,
      EV_DONE_OK,
      EV_DONE_NOSAMPLE
   } event_t;

   localparam int NUM_SHADOW = 5;   // pump, dark, mw1, fp, mw2

   // ------------------------------------------------------------------
   // Input registers and edge detection
   // ------------------------------------------------------------------
   // s_x is the registered input, p_x the copy one cycle older. sample is
   // only ever used as a level, so it has no delayed copy.
   logic [3:0] s_reg;   // {sample, MW, probe, pump}
   logic [2:0] p_reg;   // {MW, probe, pump}

   always_ff @(posedge clk_2M5) begin
      if (!rst_n) begin
         s_reg <= '0;
         p_reg <= '0;
      end else begin
         s_reg <= {sample, MW, probe, pump};
         p_reg <= s_reg[2:0];
      end
   end

   logic s_pump, s_probe, s_mw, s_sample;
   logic p_pump, p_probe, p_mw;

   assign s_pump   = s_reg[0];
   assign s_probe  = s_reg[1];
   assign s_mw     = s_reg[2];
   assign s_sample = s_reg[3];
   assign p_pump   = p_reg[0];
   assign p_probe  = p_reg[1];
   assign p_mw     = p_reg[2];

   logic pump_rise, pump_fall, probe_rise, probe_fall, mw_rise, mw_fall;

   assign pump_rise  =  s_pump  & ~p_pump;
   assign pump_fall  = ~s_pump  &  p_pump;
   assign probe_rise =  s_probe & ~p_probe;
   assign probe_fall = ~s_probe &  p_probe;
   assign mw_rise    =  s_mw    & ~p_mw;
   assign mw_fall    = ~s_mw    &  p_mw;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t      state_reg;
   state_t      state_next;
   event_t      evt_next;
   logic [15:0] count_reg;
   logic        sample_seen_reg;
   logic        result_valid_reg;
   logic        seq_error_reg;
   logic [2:0]  error_code_reg;
   logic [15:0] cycle_count_reg;
   logic [15:0] probe_width_reg;

   // Decoded actions (output process)
   logic [NUM_SHADOW-1:0] shadow_we;
   logic                  result_fire;
   logic                  error_fire;
   logic [2:0]            error_code_next;
   logic                  count_load;

   // ------------------------------------------------------------------
   // FSM process 1: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_2M5) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM process 2: next state
   // ------------------------------------------------------------------
   // Checks are ordered by priority: timeout, pump rise, probe rise,
   // MW rise, then the normal per-state advance (MW fall / probe fall).
   logic early_state;     // states before WAIT_PROBE where probe must stay low
   logic mw_rise_ok;      // states where a MW rise is the expected event
   logic probe_done;      // the cycle-closing probe fall
   logic sample_ok;

   assign early_state = (state_reg == ST_PUMP) || (state_reg == ST_DARK) ||
                        (state_reg == ST_MW1)  || (state_reg == ST_FP)   ||
                        (state_reg == ST_MW2);
   assign mw_rise_ok  = (state_reg == ST_DARK) || (state_reg == ST_FP);
   assign probe_done  = (state_reg == ST_PROBE) && probe_fall;
   // The probe-fall cycle itself is still a PROBE cycle, so its sample
   // level counts too.
   assign sample_ok   = sample_seen_reg | s_sample;

   always_comb begin
      state_next = state_reg;
      evt_next   = EV_NONE;
      if ((state_reg != ST_IDLE) && (count_reg >= TIMEOUT)) begin
         evt_next   = EV_TIMEOUT;
         state_next = ST_IDLE;
      end else if (state_reg == ST_IDLE) begin
         if (pump_rise) begin
            evt_next   = EV_ADVANCE;
            state_next = ST_PUMP;
         end
      end else if (pump_rise && !probe_done) begin
         // A new pump pulse aborts the current cycle but is itself measured.
         evt_next   = EV_PUMP_ERR;
         state_next = ST_PUMP;
      end else if (probe_rise && early_state) begin
         evt_next   = EV_PROBE_ERR;
         state_next = ST_IDLE;
      end else if (mw_rise && !mw_rise_ok) begin
         evt_next   = EV_MW_ERR;
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_PUMP: begin
               if (pump_fall) begin
                  evt_next   = EV_ADVANCE;
                  state_next = ST_DARK;
               end
            end
            ST_DARK: begin
               if (mw_rise) begin
                  evt_next   = EV_ADVANCE;
                  state_next = ST_MW1;
               end
            end
            ST_MW1: begin
               if (mw_fall) begin
                  evt_next   = EV_ADVANCE;
                  state_next = ST_FP;
               end
            end
            ST_FP: begin
               if (mw_rise) begin
                  evt_next   = EV_ADVANCE;
                  state_next = ST_MW2;
               end
            end
            ST_MW2: begin
               if (mw_fall) begin
                  evt_next   = EV_ADVANCE;
                  state_next = ST_WAIT_PROBE;
               end
            end
            ST_WAIT_PROBE: begin
               if (probe_rise) begin
                  evt_next   = EV_ADVANCE;
                  state_next = ST_PROBE;
               end
            end
            ST_PROBE: begin
               if (probe_fall) begin
                  evt_next   = sample_ok ? EV_DONE_OK : EV_DONE_NOSAMPLE;
                  // Back-to-back cycles: a pump rise on the closing probe
                  // fall starts the next measurement directly.
                  state_next = pump_rise ? ST_PUMP : ST_IDLE;
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // FSM process 3: output decode
   // ------------------------------------------------------------------
   always_comb begin
      shadow_we       = '0;
      result_fire     = 1'b0;
      error_fire      = 1'b0;
      error_code_next = error_code_reg;
      case (evt_next)
         EV_ADVANCE: begin
            // Leaving a measured phase stores its duration.
            case (state_reg)
               ST_PUMP: shadow_we[0] = 1'b1;
               ST_DARK: shadow_we[1] = 1'b1;
               ST_MW1:  shadow_we[2] = 1'b1;
               ST_FP:   shadow_we[3] = 1'b1;
               ST_MW2:  shadow_we[4] = 1'b1;
               default: shadow_we    = '0;
            endcase
         end
         EV_TIMEOUT: begin
            error_fire      = 1'b1;
            error_code_next = 3'd4;
         end
         EV_PUMP_ERR: begin
            error_fire      = 1'b1;
            error_code_next = 3'd1;
         end
         EV_PROBE_ERR: begin
            error_fire      = 1'b1;
            error_code_next = 3'd2;
         end
         EV_MW_ERR: begin
            error_fire      = 1'b1;
            error_code_next = 3'd3;
         end
         EV_DONE_OK: begin
            result_fire = 1'b1;
         end
         EV_DONE_NOSAMPLE: begin
            error_fire      = 1'b1;
            error_code_next = 3'd5;
         end
         default: begin
            error_fire = 1'b0;
         end
      endcase
   end

   assign count_load = (evt_next != EV_NONE);

   // ------------------------------------------------------------------
   // Duration counter and sample tracking
   // ------------------------------------------------------------------
   // Counter is 1 in the first cycle of a state, so on the cycle the exit
   // edge is seen it equals the number of cycles the phase level was held
   // at the input register.
   always_ff @(posedge clk_2M5) begin
      if (!rst_n) begin
         count_reg       <= '0;
         sample_seen_reg <= 1'b0;
      end else begin
         if (count_load) begin
            count_reg <= 16'd1;
         end else if (count_reg != 16'hFFFF) begin
            count_reg <= count_reg + 16'd1;
         end

         if (count_load) begin
            sample_seen_reg <= 1'b0;
         end else if ((state_reg == ST_PROBE) && s_sample) begin
            sample_seen_reg <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Shadow registers and published widths for the five pre-probe phases
   // ------------------------------------------------------------------
   // Shadows fill in as the cycle progresses; the visible widths only
   // change together when a cycle closes cleanly, so an aborted cycle
   // never leaks partial results.
   logic [15:0] slot_width [0:NUM_SHADOW-1];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SHADOW; gi++) begin : g_slot
         logic [15:0] shadow_reg;
         logic [15:0] width_reg;

         always_ff @(posedge clk_2M5) begin
            if (!rst_n) begin
               shadow_reg <= '0;
               width_reg  <= '0;
            end else begin
               if (shadow_we[gi]) begin
                  shadow_reg <= count_reg;
               end
               if (result_fire) begin
                  width_reg <= shadow_reg;
               end
            end
         end

         assign slot_width[gi] = width_reg;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Probe width, strobes, error code and cycle counter
   // ------------------------------------------------------------------
   // Probe width needs no shadow: its duration is final on the very cycle
   // the result is published.
   always_ff @(posedge clk_2M5) begin
      if (!rst_n) begin
         probe_width_reg  <= '0;
         result_valid_reg <= 1'b0;
         seq_error_reg    <= 1'b0;
         error_code_reg   <= '0;
         cycle_count_reg  <= '0;
      end else begin
         result_valid_reg <= result_fire;
         seq_error_reg    <= error_fire;
         error_code_reg   <= error_code_next;
         if (result_fire) begin
            probe_width_reg <= count_reg;
            cycle_count_reg <= cycle_count_reg + 16'd1;
         end
      end
   end

   assign pump_width   = slot_width[0];
   assign dark_width   = slot_width[1];
   assign mw1_width    = slot_width[2];
   assign fp_width     = slot_width[3];
   assign mw2_width    = slot_width[4];
   assign probe_width  = probe_width_reg;
   assign result_valid = result_valid_reg;
   assign seq_error    = seq_error_reg;
   assign error_code   = error_code_reg;
   assign cycle_count  = cycle_count_reg;

endmodule
